// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the LCD SPI receive path.
// Command opcodes, decoder FSM states, default panel geometry.
package lcd_spi_pkg;

  localparam logic [7:0] CMD_SET_COLUMN = 8'h2A;
  localparam logic [7:0] CMD_SET_PAGE   = 8'h2B;
  localparam logic [7:0] CMD_WRITE_RAM  = 8'h2C;

  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_IGNORE
  } state_t;

  // A 16-bit window coordinate is out of range
  // when any bit above the 9-bit address is set.
  function automatic logic coord_ovf(
    input logic [15:0] c
  );
    return |c[15:9];
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises cs/sclk/mosi/dc into clk.
// Ports: cs/sclk/mosi/dc in; rx_byte, rx_data (dc), rx_stb pulse out.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc,
  output logic [7:0] rx_byte,
  output logic       rx_data,
  output logic       rx_stb
);

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] dc_q;
  logic                   sclk_d;
  logic [6:0]             shift;
  logic [2:0]             cnt;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic dc_s;
  logic rise;

  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;

  // cs idles high so a reset link looks deselected.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_q   <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
      dc_q   <= '0;
      sclk_d <= 1'b0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], dc};
      sclk_d <= sclk_s;
    end
  end

  // Deselect drops a partial byte; 3-bit count
  // wraps to zero on the eighth edge by itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift   <= '0;
      cnt     <= '0;
      rx_byte <= '0;
      rx_data <= 1'b0;
      rx_stb  <= 1'b0;
    end else begin
      rx_stb <= 1'b0;
      if (cs_s) begin
        cnt <= '0;
      end else if (rise) begin
        shift <= {shift[5:0], mosi_s};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          rx_byte <= {shift, mosi_s};
          rx_data <= dc_s;
          rx_stb  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_lcd_rx_decoder.sv
// LCD SPI display-side decoder: CASET/PASET/RAMWR to pixel strobes.
// Ports: SPI in (cs/sclk/mosi/dc); cmd, pixel, window, error out.
module spi_lcd_rx_decoder
  import lcd_spi_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_dc,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_valid,
  output logic        o_pix_we,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [15:0] o_pix_data,
  output logic [8:0]  o_xs,
  output logic [8:0]  o_xe,
  output logic [8:0]  o_ys,
  output logic [8:0]  o_ye,
  output logic        o_err
);

  localparam logic [8:0] XE_RST = 9'(H_RES - 1);
  localparam logic [8:0] YE_RST = 9'(V_RES - 1);

  logic [7:0] rx_byte;
  logic       rx_data;
  logic       rx_stb;

  spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .cs      (i_cs),
    .sclk    (i_sclk),
    .mosi    (i_mosi),
    .dc      (i_dc),
    .rx_byte (rx_byte),
    .rx_data (rx_data),
    .rx_stb  (rx_stb)
  );

  state_t     st;
  state_t     st_n;
  logic [1:0] idx;
  logic [7:0] sh0;
  logic [7:0] sh1;
  logic [7:0] sh2;
  logic [7:0] hi_byte;
  logic [8:0] cur_x;
  logic [8:0] cur_y;

  logic        cmd_hit;
  logic        dat_hit;
  logic        last_par;
  logic        win_ok;
  logic [15:0] s16;
  logic [15:0] e16;

  logic err_n;
  logic we_n;
  logic cv_n;

  assign cmd_hit  = rx_stb & ~rx_data;
  assign dat_hit  = rx_stb & rx_data;
  assign last_par = (idx == 2'd3);
  assign win_ok   = (o_xs <= o_xe) && (o_ys <= o_ye);
  assign s16      = {sh0, sh1};
  assign e16      = {sh2, rx_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) st <= ST_IDLE;
    else       st <= st_n;
  end

  always_comb begin
    st_n = st;
    if (cmd_hit) begin
      unique case (1'b1)
        (rx_byte == CMD_SET_COLUMN): st_n = ST_CASET;
        (rx_byte == CMD_SET_PAGE):   st_n = ST_PASET;
        (rx_byte == CMD_WRITE_RAM):  st_n = ST_RAMWR_HI;
        default:                     st_n = ST_IGNORE;
      endcase
    end else if (dat_hit) begin
      case (st)
        ST_CASET,
        ST_PASET:    if (last_par) st_n = ST_IDLE;
        ST_RAMWR_HI: st_n = ST_RAMWR_LO;
        ST_RAMWR_LO: st_n = ST_RAMWR_HI;
        default:     st_n = st;
      endcase
    end
  end

  // A command aborting an unfinished window
  // or a half pixel is a protocol error.
  always_comb begin
    cv_n  = cmd_hit;
    err_n = 1'b0;
    we_n  = 1'b0;
    if (cmd_hit) begin
      err_n = (st == ST_CASET) ||
              (st == ST_PASET) ||
              (st == ST_RAMWR_LO);
    end else if (dat_hit) begin
      case (st)
        ST_IDLE: err_n = 1'b1;
        ST_CASET,
        ST_PASET: begin
          if (last_par)
            err_n = coord_ovf(s16) |
                    coord_ovf(e16);
        end
        ST_RAMWR_LO: begin
          we_n  = win_ok;
          err_n = ~win_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cmd       <= '0;
      o_cmd_valid <= 1'b0;
      o_pix_we    <= 1'b0;
      o_pix_x     <= '0;
      o_pix_y     <= '0;
      o_pix_data  <= '0;
      o_err       <= 1'b0;
      o_xs        <= '0;
      o_xe        <= XE_RST;
      o_ys        <= '0;
      o_ye        <= YE_RST;
      idx         <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      hi_byte     <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
    end else begin
      o_cmd_valid <= cv_n;
      o_pix_we    <= we_n;
      o_err       <= err_n;
      if (cmd_hit) begin
        o_cmd <= rx_byte;
        idx   <= '0;
        if (rx_byte == CMD_WRITE_RAM) begin
          cur_x <= o_xs;
          cur_y <= o_ys;
        end
      end else if (dat_hit) begin
        case (st)
          ST_CASET,
          ST_PASET: begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0:    sh0 <= rx_byte;
              2'd1:    sh1 <= rx_byte;
              2'd2:    sh2 <= rx_byte;
              default: ;
            endcase
            // Window swaps in only once all
            // four bytes have arrived.
            if (last_par) begin
              if (st == ST_CASET) begin
                o_xs <= s16[8:0];
                o_xe <= e16[8:0];
              end else begin
                o_ys <= s16[8:0];
                o_ye <= e16[8:0];
              end
            end
          end
          ST_RAMWR_HI: hi_byte <= rx_byte;
          ST_RAMWR_LO: begin
            if (win_ok) begin
              o_pix_x    <= cur_x;
              o_pix_y    <= cur_y;
              o_pix_data <= {hi_byte, rx_byte};
              if (cur_x < o_xe) begin
                cur_x <= cur_x + 9'd1;
              end else begin
                cur_x <= o_xs;
                if (cur_y < o_ye)
                  cur_y <= cur_y + 9'd1;
                else
                  cur_y <= o_ys;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx_decoder.sv
// Directed bench for spi_lcd_rx_decoder.
// Drives SPI bytes, logs strobes, checks against hand values.
module tb_spi_lcd_rx_decoder;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        dc;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        pix_we;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic [8:0]  xs;
  logic [8:0]  xe;
  logic [8:0]  ys;
  logic [8:0]  ye;
  logic        err;

  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_cv   = 0;
  logic [33:0] px_q[$];

  spi_lcd_rx_decoder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cs        (cs),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_dc        (dc),
    .o_cmd       (cmd),
    .o_cmd_valid (cmd_valid),
    .o_pix_we    (pix_we),
    .o_pix_x     (pix_x),
    .o_pix_y     (pix_y),
    .o_pix_data  (pix_data),
    .o_xs        (xs),
    .o_xe        (xe),
    .o_ys        (ys),
    .o_ye        (ye),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_we)
        px_q.push_back({pix_x, pix_y, pix_data});
      if (err)       n_err = n_err + 1;
      if (cmd_valid) n_cv  = n_cv + 1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic       d,
    input logic [7:0] b,
    input bit         pulse
  );
    dc = d;
    cs = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(8);
    if (pulse) begin
      cs = 1'b1;
      tick(4);
    end
  endtask

  task automatic c8(input logic [7:0] b);
    send(1'b0, b, 1'b0);
  endtask

  task automatic d8(input logic [7:0] b);
    send(1'b1, b, 1'b0);
  endtask

  task automatic chk_px(
    input string      tag,
    input int         k,
    input logic [8:0] x,
    input logic [8:0] y
  );
    logic [33:0] e;
    if (k < px_q.size()) e = px_q[k];
    else                 e = '1;
    chk({tag, "_x"}, 32'(e[33:25]), 32'(x));
    chk({tag, "_y"}, 32'(e[24:16]), 32'(y));
  endtask

  int e0;
  int p0;
  int v0;
  logic [33:0] pe;

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    dc   = 1'b0;
    tick(5);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_xs", 32'(xs), 32'd0);
    chk("rst_xe", 32'(xe), 32'd239);
    chk("rst_ys", 32'(ys), 32'd0);
    chk("rst_ye", 32'(ye), 32'd319);
    chk("rst_we", 32'(pix_we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(4);

    // Single-column window, three rows
    e0 = n_err; p0 = px_q.size(); v0 = n_cv;
    c8(8'h2A);
    d8(8'h00); d8(8'h0A); d8(8'h00); d8(8'h0A);
    chk("t1_cmd", 32'(cmd), 32'h2A);
    chk("t1_cv", 32'(n_cv - v0), 32'd1);
    chk("t1_xs", 32'(xs), 32'd10);
    chk("t1_xe", 32'(xe), 32'd10);
    c8(8'h2B);
    d8(8'h00); d8(8'h05); d8(8'h00); d8(8'h07);
    chk("t1_ys", 32'(ys), 32'd5);
    chk("t1_ye", 32'(ye), 32'd7);
    c8(8'h2C);
    for (int i = 0; i < 6; i++) d8(8'hFF);
    chk("t1_npix", 32'(px_q.size() - p0), 32'd3);
    chk_px("t1_p0", p0,     9'd10, 9'd5);
    chk_px("t1_p1", p0 + 1, 9'd10, 9'd6);
    chk_px("t1_p2", p0 + 2, 9'd10, 9'd7);
    pe = (p0 + 2 < px_q.size()) ? px_q[p0 + 2] : '0;
    chk("t1_data", 32'(pe[15:0]), 32'hFFFF);
    chk("t1_err", 32'(n_err - e0), 32'd0);

    // 2x2 window, five pixels wrap
    e0 = n_err; p0 = px_q.size();
    c8(8'h2A);
    d8(8'h00); d8(8'h00); d8(8'h00); d8(8'h01);
    c8(8'h2B);
    d8(8'h00); d8(8'h00); d8(8'h00); d8(8'h01);
    c8(8'h2C);
    for (int i = 0; i < 5; i++) begin
      d8(8'hA0 + 8'(i));
      d8(8'hB0 + 8'(i));
    end
    chk("t2_npix", 32'(px_q.size() - p0), 32'd5);
    chk_px("t2_p0", p0,     9'd0, 9'd0);
    chk_px("t2_p1", p0 + 1, 9'd1, 9'd0);
    chk_px("t2_p2", p0 + 2, 9'd0, 9'd1);
    chk_px("t2_p3", p0 + 3, 9'd1, 9'd1);
    chk_px("t2_p4", p0 + 4, 9'd0, 9'd0);
    pe = (p0 < px_q.size()) ? px_q[p0] : '0;
    chk("t2_d0", 32'(pe[15:0]), 32'hA0B0);
    pe = (p0 + 4 < px_q.size()) ? px_q[p0 + 4] : '0;
    chk("t2_d4", 32'(pe[15:0]), 32'hA4B4);
    chk("t2_err", 32'(n_err - e0), 32'd0);

    // CS toggled between every byte
    e0 = n_err;
    send(1'b0, 8'h2A, 1'b1);
    send(1'b1, 8'h00, 1'b1);
    send(1'b1, 8'h03, 1'b1);
    send(1'b1, 8'h00, 1'b1);
    send(1'b1, 8'h20, 1'b1);
    chk("t3_xs", 32'(xs), 32'd3);
    chk("t3_xe", 32'(xe), 32'h20);
    chk("t3_err", 32'(n_err - e0), 32'd0);

    // Partial byte dropped by CS
    e0 = n_err;
    dc = 1'b0;
    cs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs = 1'b1;
    tick(6);
    c8(8'h2B);
    chk("t4_cmd", 32'(cmd), 32'h2B);
    chk("t4_err", 32'(n_err - e0), 32'd0);
    d8(8'h00); d8(8'h00); d8(8'h01); d8(8'h3F);
    chk("t4_ye", 32'(ye), 32'd319);

    // Coordinate >= 512 truncates, errors
    e0 = n_err;
    c8(8'h2A);
    d8(8'h02); d8(8'h00); d8(8'h00); d8(8'h05);
    chk("ovf_err", 32'(n_err - e0), 32'd1);
    chk("ovf_xs", 32'(xs), 32'd0);
    chk("ovf_xe", 32'(xe), 32'd5);

    // Inverted window suppresses pixels
    c8(8'h2A);
    d8(8'h00); d8(8'h05); d8(8'h00); d8(8'h02);
    e0 = n_err; p0 = px_q.size();
    c8(8'h2C);
    d8(8'h11); d8(8'h22);
    chk("inv_err", 32'(n_err - e0), 32'd1);
    chk("inv_we", 32'(px_q.size() - p0), 32'd0);

    // Half pixel aborted by command
    e0 = n_err; p0 = px_q.size(); v0 = n_cv;
    c8(8'h2C);
    d8(8'h33);
    c8(8'h2A);
    chk("t5_err", 32'(n_err - e0), 32'd1);
    chk("t5_we", 32'(px_q.size() - p0), 32'd0);
    chk("t5_cmd", 32'(cmd), 32'h2A);
    chk("t5_cv", 32'(n_cv - v0), 32'd2);

    // Reset in the middle of RAMWR
    c8(8'h2C);
    d8(8'h44);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cmd", 32'(cmd), 32'h0);
    chk("t6_xs", 32'(xs), 32'd0);
    chk("t6_xe", 32'(xe), 32'd239);
    chk("t6_ye", 32'(ye), 32'd319);
    chk("t6_px", 32'(pix_x), 32'd0);
    tick(2);
    rst = 1'b0;
    cs  = 1'b1;
    tick(6);
    e0 = n_err; p0 = px_q.size();
    d8(8'h55);
    chk("t6_err", 32'(n_err - e0), 32'd1);
    chk("t6_we", 32'(px_q.size() - p0), 32'd0);

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
